// File: rtl/banked_data_mem.sv
// Single-port data memory with a request/response handshake, byte/half/word access,
// fault detection (bad size, out of range, misaligned) and a fixed access latency.
module banked_data_mem #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  resp_code,
    output logic [15:0] err_count
);

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [2:0] WAIT_INIT = 3'(LATENCY >= 2 ? LATENCY - 2 : 0);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [1:0] CODE_OK       = 2'b00;
    localparam logic [1:0] CODE_MISALIGN = 2'b01;
    localparam logic [1:0] CODE_RANGE    = 2'b10;
    localparam logic [1:0] CODE_SIZE     = 2'b11;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateType;

    stateType              stateReg, stateNext;
    logic [2:0]            waitCntReg, waitCntNext;
    logic                  weReg, signedReg, errReg;
    logic [1:0]            sizeReg, laneReg, codeReg;
    logic [DEPTH_LOG2-1:0] idxReg;
    logic [31:0]           wdataReg;
    logic [15:0]           errCountReg;

    logic                  accept;
    logic [31:0]           reqOffset;
    logic [DEPTH_LOG2-1:0] reqIdx;
    logic [1:0]            reqLane;
    logic                  reqOutOfRange;
    logic [1:0]            reqCode;

    logic                  doAccess;
    logic                  accWe;
    logic [1:0]            accSize, accLane;
    logic [DEPTH_LOG2-1:0] accIdx;
    logic [31:0]           accWdata;
    logic [31:0]           rdWord;
    logic [7:0]            byteSel;
    logic [15:0]           halfSel;
    logic [31:0]           respData;

    assign req_ready = (stateReg == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // Addresses below BASE_ADDR wrap to huge offsets and so land out of range.
    assign reqOffset     = req_addr - BASE_ADDR;
    assign reqIdx        = reqOffset[DEPTH_LOG2+1:2];
    assign reqLane       = reqOffset[1:0];
    assign reqOutOfRange = |reqOffset[31:DEPTH_LOG2+2];

    always_comb begin
        reqCode = CODE_OK;
        if (req_size == 2'b11) begin
            reqCode = CODE_SIZE;
        end else if (reqOutOfRange) begin
            reqCode = CODE_RANGE;
        end else if ((req_size == SIZE_HALF && reqLane[0]) ||
                     (req_size == SIZE_WORD && reqLane != 2'b00)) begin
            reqCode = CODE_MISALIGN;
        end
    end

    // With LATENCY = 1 the access happens on the acceptance edge, so it uses the live request.
    assign accWe    = (stateReg == IDLE) ? req_we    : weReg;
    assign accSize  = (stateReg == IDLE) ? req_size  : sizeReg;
    assign accLane  = (stateReg == IDLE) ? reqLane   : laneReg;
    assign accIdx   = (stateReg == IDLE) ? reqIdx    : idxReg;
    assign accWdata = (stateReg == IDLE) ? req_wdata : wdataReg;

    assign doAccess = !rst &&
                      (((stateReg == IDLE) && accept && (reqCode == CODE_OK) && (LATENCY == 1)) ||
                       ((stateReg == WAIT) && (waitCntReg == 3'd0)));

    always_comb begin
        stateNext   = stateReg;
        waitCntNext = waitCntReg;
        case (stateReg)
            IDLE: begin
                if (accept) begin
                    if (reqCode != CODE_OK || LATENCY == 1) begin
                        stateNext = RESP;
                    end else begin
                        stateNext   = WAIT;
                        waitCntNext = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (waitCntReg == 3'd0) begin
                    stateNext = RESP;
                end else begin
                    waitCntNext = waitCntReg - 3'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg    <= IDLE;
            waitCntReg  <= 3'd0;
            errReg      <= 1'b0;
            codeReg     <= CODE_OK;
            errCountReg <= 16'd0;
        end else begin
            stateReg   <= stateNext;
            waitCntReg <= waitCntNext;
            if (accept) begin
                errReg  <= (reqCode != CODE_OK);
                codeReg <= reqCode;
                if (reqCode != CODE_OK && errCountReg != 16'hFFFF) begin
                    errCountReg <= errCountReg + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            weReg     <= req_we;
            sizeReg   <= req_size;
            signedReg <= req_signed;
            laneReg   <= reqLane;
            idxReg    <= reqIdx;
            wdataReg  <= req_wdata;
        end
    end

    // One byte-wide RAM per lane so partial stores need no read-modify-write.
    for (genvar gi = 0; gi < 4; gi++) begin : gLane
        localparam logic [1:0] LANE_ID = 2'(gi);

        logic [7:0] laneMem [0:DEPTH-1];
        logic [7:0] rdByteReg;
        logic       laneWe;
        logic [7:0] laneData;

        always_comb begin
            laneWe   = 1'b0;
            laneData = 8'd0;
            case (accSize)
                SIZE_BYTE: begin
                    laneWe   = (accLane == LANE_ID);
                    laneData = accWdata[7:0];
                end
                SIZE_HALF: begin
                    laneWe   = (accLane[1] == LANE_ID[1]);
                    laneData = accWdata[8*(gi%2) +: 8];
                end
                SIZE_WORD: begin
                    laneWe   = 1'b1;
                    laneData = accWdata[8*gi +: 8];
                end
                default: begin
                    laneWe   = 1'b0;
                    laneData = 8'd0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (doAccess) begin
                if (accWe && laneWe) begin
                    laneMem[accIdx] <= laneData;
                end
                rdByteReg <= laneMem[accIdx];
            end
        end

        assign rdWord[8*gi +: 8] = rdByteReg;
    end

    always_comb begin
        case (laneReg)
            2'd0:    byteSel = rdWord[7:0];
            2'd1:    byteSel = rdWord[15:8];
            2'd2:    byteSel = rdWord[23:16];
            default: byteSel = rdWord[31:24];
        endcase
        halfSel = laneReg[1] ? rdWord[31:16] : rdWord[15:0];
    end

    always_comb begin
        respData = 32'd0;
        if (stateReg == RESP && !errReg && !weReg) begin
            case (sizeReg)
                SIZE_BYTE: respData = {{24{signedReg & byteSel[7]}}, byteSel};
                SIZE_HALF: respData = {{16{signedReg & halfSel[15]}}, halfSel};
                SIZE_WORD: respData = rdWord;
                default:   respData = 32'd0;
            endcase
        end
    end

    assign resp_valid = (stateReg == RESP);
    assign resp_err   = (stateReg == RESP) && errReg;
    assign resp_code  = (stateReg == RESP) ? codeReg : CODE_OK;
    assign resp_rdata = respData;
    assign err_count  = errCountReg;

endmodule

// File: tb/tb_banked_data_mem.sv
// Directed bench for banked_data_mem: latency, lane stores, extension, faults,
// backpressure, reset abort and request spacing.
module tb_banked_data_mem;

    localparam int          DL2  = 10;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  resp_code;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;

    int          lat;
    logic [31:0] rd;
    logic        er;
    logic [1:0]  cd;
    logic [15:0] ec;

    always #5 clk = ~clk;

    banked_data_mem #(.DEPTH_LOG2(DL2), .BASE_ADDR(BASE), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .resp_code(resp_code), .err_count(err_count)
    );

    // Issue one request, measure edges from acceptance to resp_valid, then hand off.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int olat, output logic [31:0] ordata, output logic oerr,
                         output logic [1:0] ocode, output logic [15:0] ocnt);
        int guard = 0;
        olat = 99; ordata = 32'hxxxx_xxxx; oerr = 1'bx; ocode = 2'bxx; ocnt = 16'hxxxx;
        @(negedge clk);
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            $display("txn we=%0d size=%0d addr=%h: request never accepted", we, size, addr);
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        olat = 1;
        while (!resp_valid && olat < 20) begin
            @(posedge clk); #1;
            olat++;
        end
        if (!resp_valid) olat = 99;
        ordata = resp_rdata; oerr = resp_err; ocode = resp_code; ocnt = err_count;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        $display("txn we=%0d size=%0d sgn=%0d addr=%h wdata=%h -> lat=%0d rdata=%h err=%0d code=%0d cnt=%0d",
                 we, size, sgn, addr, wdata, olat, ordata, oerr, ocode, ocnt);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err: got %b want 0", resp_err); end
        checks++; if (resp_code !== 2'b00) begin errors++; $display("FAIL rst_resp_code: got %b want 00", resp_code); end
        checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL rst_resp_rdata: got %h want 0", resp_rdata); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL rst_err_count: got %0d want 0", err_count); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b want 1", req_ready); end
        $display("txn reset released");
    endtask

    task automatic test_word();
        issue(1'b1, 2'b10, 1'b0, BASE + 32'd8, 32'hDEAD_BEEF, lat, rd, er, cd, ec);
        checks++; if (lat !== 2) begin errors++; $display("FAIL st_word_lat: got %0d want 2", lat); end
        checks++; if (rd !== 32'd0 || er !== 1'b0) begin errors++; $display("FAIL st_word_resp: got rdata=%h err=%b want 0/0", rd, er); end
        issue(1'b0, 2'b10, 1'b0, BASE + 32'd8, 32'd0, lat, rd, er, cd, ec);
        checks++; if (lat !== 2) begin errors++; $display("FAIL ld_word_lat: got %0d want 2", lat); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld_word_data: got %h want deadbeef", rd); end
        // Last in-range word.
        issue(1'b1, 2'b10, 1'b0, BASE + 32'd4092, 32'hCAFE_F00D, lat, rd, er, cd, ec);
        issue(1'b0, 2'b10, 1'b0, BASE + 32'd4092, 32'd0, lat, rd, er, cd, ec);
        checks++; if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin errors++; $display("FAIL ld_last_word: got %h err=%b want cafef00d/0", rd, er); end
    endtask

    task automatic test_byte_half();
        issue(1'b1, 2'b00, 1'b0, BASE + 32'd11, 32'h1234_5680, lat, rd, er, cd, ec);
        issue(1'b0, 2'b10, 1'b0, BASE + 32'd8, 32'd0, lat, rd, er, cd, ec);
        checks++; if (rd !== 32'h80AD_BEEF) begin errors++; $display("FAIL byte_merge: got %h want 80adbeef", rd); end
        issue(1'b0, 2'b00, 1'b1, BASE + 32'd11, 32'd0, lat, rd, er, cd, ec);
        checks++; if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL ld_byte_signed: got %h want ffffff80", rd); end
        issue(1'b0, 2'b00, 1'b0, BASE + 32'd11, 32'd0, lat, rd, er, cd, ec);
        checks++; if (rd !== 32'h0000_0080) begin errors++; $display("FAIL ld_byte_unsigned: got %h want 00000080", rd); end
        issue(1'b0, 2'b01, 1'b1, BASE + 32'd10, 32'd0, lat, rd, er, cd, ec);
        checks++; if (rd !== 32'hFFFF_80AD) begin errors++; $display("FAIL ld_half_signed: got %h want ffff80ad", rd); end
        issue(1'b0, 2'b01, 1'b0, BASE + 32'd8, 32'd0, lat, rd, er, cd, ec);
        checks++; if (rd !== 32'h0000_BEEF) begin errors++; $display("FAIL ld_half_unsigned: got %h want 0000beef", rd); end
    endtask

    task automatic test_faults();
        issue(1'b0, 2'b01, 1'b0, BASE + 32'd1, 32'd0, lat, rd, er, cd, ec);
        checks++; if (lat !== 1) begin errors++; $display("FAIL misalign_lat: got %0d want 1", lat); end
        checks++; if (er !== 1'b1 || cd !== 2'b01) begin errors++; $display("FAIL misalign_code: got err=%b code=%b want 1/01", er, cd); end
        checks++; if (rd !== 32'd0 || ec !== 16'd1) begin errors++; $display("FAIL misalign_data_cnt: got %h/%0d want 0/1", rd, ec); end
        issue(1'b1, 2'b10, 1'b0, BASE + 32'd9, 32'hFFFF_FFFF, lat, rd, er, cd, ec);
        checks++; if (cd !== 2'b01 || ec !== 16'd2) begin errors++; $display("FAIL misalign_store: got code=%b cnt=%0d want 01/2", cd, ec); end
        issue(1'b0, 2'b10, 1'b0, BASE + 32'd8, 32'd0, lat, rd, er, cd, ec);
        checks++; if (rd !== 32'h80AD_BEEF) begin errors++; $display("FAIL mem_unchanged: got %h want 80adbeef", rd); end
        issue(1'b0, 2'b10, 1'b0, BASE + (32'd4 << DL2), 32'd0, lat, rd, er, cd, ec);
        checks++; if (er !== 1'b1 || cd !== 2'b10 || ec !== 16'd3) begin errors++; $display("FAIL range_top: got err=%b code=%b cnt=%0d want 1/10/3", er, cd, ec); end
        issue(1'b0, 2'b10, 1'b0, BASE - 32'd4, 32'd0, lat, rd, er, cd, ec);
        checks++; if (er !== 1'b1 || cd !== 2'b10 || ec !== 16'd4) begin errors++; $display("FAIL range_below: got err=%b code=%b cnt=%0d want 1/10/4", er, cd, ec); end
        issue(1'b0, 2'b11, 1'b0, BASE - 32'd3, 32'd0, lat, rd, er, cd, ec);
        checks++; if (er !== 1'b1 || cd !== 2'b11 || ec !== 16'd5) begin errors++; $display("FAIL bad_size: got err=%b code=%b cnt=%0d want 1/11/5", er, cd, ec); end
    endtask

    task automatic test_backpressure();
        int wt = 0;
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = BASE + 32'd8;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        while (!resp_valid && wt < 20) begin
            @(posedge clk); #1;
            wt++;
        end
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_resp_timeout: got %b want 1", resp_valid); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h80AD_BEEF || req_ready !== 1'b0 || resp_err !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got valid=%b rdata=%h ready=%b err=%b want 1/80adbeef/0/0",
                         c, resp_valid, resp_rdata, req_ready, resp_err);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1", resp_valid, req_ready); end
        $display("txn backpressure load held 5 cycles");
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b10; req_addr = BASE + 32'd8; req_wdata = 32'h1111_1111;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL abort_outputs: got valid=%b ready=%b want 0/0", resp_valid, req_ready); end
        checks++; if (err_count !== 16'd0 || resp_code !== 2'b00 || resp_rdata !== 32'd0) begin errors++; $display("FAIL abort_regs: got cnt=%0d code=%b rdata=%h want 0/00/0", err_count, resp_code, resp_rdata); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL abort_no_resp: got %b want 0", resp_valid); end
        $display("txn store aborted by reset");
        issue(1'b0, 2'b10, 1'b0, BASE + 32'd8, 32'd0, lat, rd, er, cd, ec);
        checks++; if (rd !== 32'h80AD_BEEF || ec !== 16'd0) begin errors++; $display("FAIL abort_no_write: got %h cnt=%0d want 80adbeef/0", rd, ec); end
    endtask

    task automatic test_back_to_back();
        int accCyc[$];
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_addr = BASE + 32'd8;
        req_valid = 1'b1;
        resp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (req_ready) accCyc.push_back(c);
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        resp_ready = 1'b0;
        checks++; if (accCyc.size() !== 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", accCyc.size()); end
        checks++;
        if (accCyc.size() < 2) begin
            errors++; $display("FAIL b2b_spacing: got fewer than 2 acceptances want spacing 3");
        end else if (accCyc[1] - accCyc[0] !== 3) begin
            errors++; $display("FAIL b2b_spacing: got %0d want 3", accCyc[1] - accCyc[0]);
        end
        $display("txn back-to-back loads accepted=%0d", accCyc.size());
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_half();
        test_faults();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
